seg_display_scan: RTL and testbench

- Downstream display stage for the stopwatch: takes four BCD digits (MM:SS) plus adjust/select status and drives the 4-digit common-anode seven-segment display.
- Time-multiplexes the digits at a fixed scan rate and blinks the digit pair being adjusted.
- Produces the board-level segment_num/segment_values signals; the stopwatch core only supplies digit values.

---
 rtl/seg_display_scan_if.sv | 25 ++
 rtl/seg_display_scan.sv | 106 ++++++++++
 tb/tb_seg_display_scan.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/seg_display_scan_if.sv
// Digit/status inputs and segment drive outputs of the 4-digit scan display.
// master = digit source / board side, slave = the scan stage.
interface seg_display_scan_if;
  logic [15:0] digits;
  logic        adjust;
  logic        select;
  logic [3:0]  segment_num;
  logic [6:0]  segment_values;

  modport master (
    output digits,
    output adjust,
    output select,
    input  segment_num,
    input  segment_values
  );

  modport slave (
    input  digits,
    input  adjust,
    input  select,
    output segment_num,
    output segment_values
  );
endinterface

// File: rtl/seg_display_scan.sv
// Multiplexed MM:SS common-anode display driver with adjust-pair blinking.
// Optional SEG_LEADING_ZERO_BLANK_EN blanks a zero minutes-tens digit.
module seg_display_scan #(
  parameter int SCAN_DIV  = 100000,
  parameter int BLINK_DIV = 25000000
) (
  input  logic              clock_100mhz,
  input  logic              reset_n,
  seg_display_scan_if.slave bus
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(BLINK_DIV);

  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [6:0]    BLANK      = 7'h7F;

  logic [SW-1:0] scan_q, scan_d;
  logic [BW-1:0] blink_q, blink_d;
  logic [1:0]    idx_q, idx_d;
  logic          phase_q, phase_d;
  logic [3:0]    num_q, num_d;
  logic [6:0]    val_q, val_d;

  logic [3:0]    nib;
  logic          in_pair;
  logic          blank;
  logic          lz;

  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = BLANK;
    endcase
    return s;
  endfunction

  always_comb begin
    scan_d  = scan_q + SW'(1);
    idx_d   = idx_q;
    if (scan_q == SCAN_LAST) begin
      scan_d = '0;
      idx_d  = idx_q + 2'd1;
    end

    blink_d = blink_q + BW'(1);
    phase_d = phase_q;
    if (blink_q == BLINK_LAST) begin
      blink_d = '0;
      phase_d = ~phase_q;
    end

    case (idx_q)
      2'd0:    nib = bus.digits[3:0];
      2'd1:    nib = bus.digits[7:4];
      2'd2:    nib = bus.digits[11:8];
      default: nib = bus.digits[15:12];
    endcase

    // select=1 -> seconds pair (idx 0,1); select=0 -> minutes pair (idx 2,3)
    in_pair = bus.select ? ~idx_q[1] : idx_q[1];
    blank   = bus.adjust & phase_q & in_pair;

`ifdef SEG_LEADING_ZERO_BLANK_EN
    lz = (idx_q == 2'd3) && (bus.digits[15:12] == 4'd0);
`else
    lz = 1'b0;
`endif

    num_d = ~(4'b0001 << idx_q);
    val_d = (blank | lz) ? BLANK : decode(nib);
  end

  always_ff @(posedge clock_100mhz or negedge reset_n) begin
    if (!reset_n) begin
      scan_q  <= '0;
      blink_q <= '0;
      idx_q   <= 2'd0;
      phase_q <= 1'b0;
      num_q   <= 4'b1111;
      val_q   <= BLANK;
    end else begin
      scan_q  <= scan_d;
      blink_q <= blink_d;
      idx_q   <= idx_d;
      phase_q <= phase_d;
      num_q   <= num_d;
      val_q   <= val_d;
    end
  end

  assign bus.segment_num    = num_q;
  assign bus.segment_values = val_q;

endmodule

// File: tb/tb_seg_display_scan.sv
// Scoreboard bench for seg_display_scan with SCAN_DIV=4, BLINK_DIV=16.
// Slot k after reset release shows idx ((k-1)/4)%4, blink phase ((k-1)/16)%2.
module tb_seg_display_scan;

  logic clk;
  logic reset_n;
  int   cyc;
  int   tests;
  int   fails;

  typedef struct {
    int         cyc;
    logic [3:0] num;
    logic [6:0] val;
    string      tag;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  seg_display_scan_if bus ();

  seg_display_scan #(
    .SCAN_DIV (4),
    .BLINK_DIV(16)
  ) dut (
    .clock_100mhz(clk),
    .reset_n     (reset_n),
    .bus         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // edge count since reset release; edge k updates outputs for slot k
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  function automatic void push(int c, logic [3:0] n, logic [6:0] v,
                               string t);
    exp_t x;
    x.cyc = c;
    x.num = n;
    x.val = v;
    x.tag = t;
    sb.push_back(x);
  endfunction

  task automatic chk(string t, logic [3:0] n, logic [6:0] v);
    tests++;
    if (bus.segment_num !== n || bus.segment_values !== v) begin
      fails++;
      $display("FAIL %s: got %b/%h want %b/%h", t,
               bus.segment_num, bus.segment_values, n, v);
    end
  endtask

  // monitor: compares queued expectations at their cycle
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n && cyc >= 1) begin
        if ($countones(~bus.segment_num) != 1) begin
          tests++;
          fails++;
          $display("FAIL onehot cyc%0d: got %b want one low",
                   cyc, bus.segment_num);
        end
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
          e = sb.pop_front();
          if (e.cyc < cyc) begin
            tests++;
            fails++;
            $display("FAIL %s: missed cyc %0d, now %0d",
                     e.tag, e.cyc, cyc);
          end else begin
            chk(e.tag, e.num, e.val);
          end
        end
      end
    end
  end

  task automatic wait_cyc(int n);
    int g = 0;
    while (cyc < n) begin
      @(negedge clk);
      g++;
      if (g > 500) begin
        tests++;
        fails++;
        $display("FAIL wait_cyc: got cyc %0d want %0d", cyc, n);
        break;
      end
    end
  endtask

  task automatic wait_drain();
    int g = 0;
    while (sb.size() > 0) begin
      @(negedge clk);
      g++;
      if (g > 500) begin
        tests++;
        fails++;
        $display("FAIL drain: got %0d pending want 0", sb.size());
        sb.delete();
        break;
      end
    end
    @(negedge clk);
  endtask

  task automatic apply_reset(string t);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk(t, 4'b1111, 7'h7F);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset_n = 1'b0;
    bus.digits = 16'h1234;
    bus.adjust = 1'b0;
    bus.select = 1'b0;
    repeat (2) @(negedge clk);

    // basic scan order
    apply_reset("rst_init");
    push(1,  4'b1110, 7'h19, "scan_d0_first");
    push(4,  4'b1110, 7'h19, "scan_d0_last");
    push(5,  4'b1101, 7'h30, "scan_d1");
    push(9,  4'b1011, 7'h24, "scan_d2");
    push(13, 4'b0111, 7'h79, "scan_d3");
    push(17, 4'b1110, 7'h19, "scan_wrap");
    wait_drain();

    // reset while digit 2 is displayed
    wait_cyc(26);
    apply_reset("rst_midscan");
    push(1, 4'b1110, 7'h19, "restart_d0");
    wait_drain();

    // blink minutes pair
    bus.digits = 16'h5907;
    bus.adjust = 1'b1;
    bus.select = 1'b0;
    apply_reset("rst_blink_min");
    push(2,  4'b1110, 7'h78, "bm_p0_d0");
    push(6,  4'b1101, 7'h40, "bm_p0_d1");
    push(10, 4'b1011, 7'h10, "bm_p0_d2");
    push(14, 4'b0111, 7'h12, "bm_p0_d3");
    push(18, 4'b1110, 7'h78, "bm_p1_d0");
    push(22, 4'b1101, 7'h40, "bm_p1_d1");
    push(26, 4'b1011, 7'h7F, "bm_p1_d2");
    push(30, 4'b0111, 7'h7F, "bm_p1_d3");
    wait_drain();

    // blink seconds pair, adjust dropped during digit 1
    bus.select = 1'b1;
    apply_reset("rst_blink_sec");
    push(18, 4'b1110, 7'h7F, "bs_p1_d0");
    push(22, 4'b1101, 7'h7F, "bs_p1_d1");
    push(23, 4'b1101, 7'h7F, "bs_p1_d1_pre");
    push(24, 4'b1101, 7'h40, "bs_adj_off");
    push(26, 4'b1011, 7'h10, "bs_p1_d2");
    push(30, 4'b0111, 7'h12, "bs_p1_d3");
    wait_cyc(23);
    bus.adjust = 1'b0;
    wait_drain();

    // out-of-range blank and mid-slot digit change
    bus.digits = 16'hA000;
    bus.select = 1'b0;
    apply_reset("rst_range");
    push(2,  4'b1110, 7'h40, "mid_before");
    push(3,  4'b1110, 7'h00, "mid_after");
    push(14, 4'b0111, 7'h7F, "range_blank");
    wait_cyc(2);
    bus.digits = 16'hA008;
    wait_drain();

    // leading zero on minutes tens
    bus.digits = 16'h0123;
    apply_reset("rst_lz");
    push(10, 4'b1011, 7'h79, "lz_d2");
`ifdef SEG_LEADING_ZERO_BLANK_EN
    push(14, 4'b0111, 7'h7F, "lz_d3");
`else
    push(14, 4'b0111, 7'h40, "lz_d3");
`endif
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
